// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings for the sMIPS data-memory controller: access sizes, FSM states,
// default bus timing, and the alignment rule used at request acceptance.
package dmem_ctrl_pkg;

    localparam int BUS_CYCLES_DEF = 2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD    = 3'd1;
    localparam logic [2:0] S_MERGE = 3'd2;
    localparam logic [2:0] S_WR    = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    // A request is rejected when its size is illegal or it straddles its natural boundary.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return (size == SZ_ILL)
            || (size == SZ_HALF && addr_lo[0])
            || (size == SZ_WORD && addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane datapath: lane mask, load extract/extend, and store data build.
// With DMEM_RMW_EN the store path merges into the read word, otherwise it replicates.
module dmem_lane
    import dmem_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        sext,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [3:0]  lane_mask,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [31:0] rshift;

    assign rshift = rword >> {addr_lo, 3'b000};

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        lane_mask = 4'b1111;
        load_data = rword;
        case (size)
            SZ_BYTE: begin
                lane_mask = 4'b0001 << addr_lo;
                load_data = {{24{sext & rshift[7]}}, rshift[7:0]};
            end
            SZ_HALF: begin
                lane_mask = 4'b0011 << addr_lo;
                load_data = {{16{sext & rshift[15]}}, rshift[15:0]};
            end
            default: ;
        endcase
    end

`ifdef DMEM_RMW_EN
    logic [31:0] mask32;
    logic [31:0] wshift;

    assign mask32 = {{8{lane_mask[3]}}, {8{lane_mask[2]}}, {8{lane_mask[1]}}, {8{lane_mask[0]}}};
    assign wshift = wdata << {addr_lo, 3'b000};
    assign store_data = (rword & ~mask32) | (wshift & mask32);
`else
    always_comb begin
        case (size)
            SZ_BYTE: store_data = {4{wdata[7:0]}};
            SZ_HALF: store_data = {2{wdata[15:0]}};
            default: store_data = wdata;
        endcase
    end
`endif

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory controller: one CPU load/store becomes a multi-cycle bus access.
// Define DMEM_RMW_EN for read-modify-write sub-word stores.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int BUS_CYCLES = BUS_CYCLES_DEF
)
(
    input  logic        sck,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic [31:0] rdata,
    output logic        addr_err,
    output logic        bus_en,
    output logic        bus_rw,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata
);

    localparam logic [2:0] CNT_LAST = 3'(BUS_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;

    logic        idle;
    logic        last;
    logic [1:0]  l_size;
    logic [1:0]  l_lo;
    logic        l_sext;
    logic [31:0] l_rword;
    logic [31:0] l_wdata;
    logic [3:0]  lane_mask;
    logic [31:0] load_data;
    logic [31:0] store_data;

    assign idle = (state_q == S_IDLE);
    assign last = (cnt_q == CNT_LAST);

    // While idle the lane logic sees the incoming request so store data is ready at acceptance.
    assign l_size = idle ? size : size_q;
    assign l_lo   = idle ? addr[1:0] : addr_lo_q;
    assign l_sext = sext_q;

`ifdef DMEM_RMW_EN
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rword_q, rword_d;

    assign l_wdata = idle ? wdata : wdata_q;
    assign l_rword = (state_q == S_RD) ? bus_rdata : rword_q;
`else
    assign l_wdata = wdata;
    assign l_rword = bus_rdata;
`endif

    dmem_lane u_lane (
        .size       (l_size),
        .addr_lo    (l_lo),
        .sext       (l_sext),
        .rword      (l_rword),
        .wdata      (l_wdata),
        .lane_mask  (lane_mask),
        .load_data  (load_data),
        .store_data (store_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        size_d      = size_q;
        sext_d      = sext_q;
        addr_lo_d   = addr_lo_q;
        rdata_d     = rdata_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
`ifdef DMEM_RMW_EN
        wdata_d     = wdata_q;
        rword_d     = rword_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d        = we;
                    size_d      = size;
                    sext_d      = sext;
                    addr_lo_d   = addr[1:0];
                    bus_addr_d  = {addr[31:2], 2'b00};
                    bus_wdata_d = store_data;
                    cnt_d       = 3'd0;
`ifdef DMEM_RMW_EN
                    wdata_d     = wdata;
`endif
                    if (misaligned(size, addr[1:0])) begin
                        state_d = S_ERR;
                    end else if (!we) begin
                        state_d = S_RD;
`ifdef DMEM_RMW_EN
                    end else if (size != SZ_WORD) begin
                        state_d = S_RD;
`endif
                    end else begin
                        state_d = S_WR;
                    end
                end
            end
            S_RD: begin
                if (last) begin
                    cnt_d = 3'd0;
                    if (we_q) begin
`ifdef DMEM_RMW_EN
                        rword_d = bus_rdata;
                        state_d = S_MERGE;
`else
                        state_d = S_WR;
`endif
                    end else begin
                        rdata_d = load_data;
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
`ifdef DMEM_RMW_EN
            S_MERGE: begin
                bus_wdata_d = store_data;
                state_d     = S_WR;
            end
`endif
            S_WR: begin
                if (last) begin
                    cnt_d   = 3'd0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            we_q        <= 1'b0;
            size_q      <= SZ_BYTE;
            sext_q      <= 1'b0;
            addr_lo_q   <= 2'b00;
            rdata_q     <= 32'd0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
`ifdef DMEM_RMW_EN
            wdata_q     <= 32'd0;
            rword_q     <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            size_q      <= size_d;
            sext_q      <= sext_d;
            addr_lo_q   <= addr_lo_d;
            rdata_q     <= rdata_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
`ifdef DMEM_RMW_EN
            wdata_q     <= wdata_d;
            rword_q     <= rword_d;
`endif
        end
    end

    // Bus strobes decode straight from state, so an async reset drops bus_en without a clock.
    assign ready     = idle;
    assign done      = (state_q == S_DONE);
    assign addr_err  = (state_q == S_ERR);
    assign bus_en    = (state_q == S_RD) || (state_q == S_WR);
    assign bus_rw    = (state_q == S_WR);
    assign bus_sel   = (state_q == S_RD) ? 4'b1111 : ((state_q == S_WR) ? lane_mask : 4'b0000);
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed scenarios plus randomized traffic
// against a byte-array memory model; expectations follow the DMEM_RMW_EN setting.
`timescale 1ns/1ps
module tb_dmem_ctrl;

    localparam int          BC   = 2;
    localparam logic [31:0] BASE = 32'h0010_0000;

    typedef struct {
        int          lat;
        int          ready_n;
        int          n_done;
        int          n_err;
        int          rd_cyc;
        int          wr_cyc;
        int          bad_addr;
        int          bad_sel;
        int          bad_wd;
        logic [31:0] wr_data;
        logic [31:0] got;
    } acc_res_t;

    logic        sck = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sext = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        ready, done, addr_err, bus_en, bus_rw;
    logic [31:0] rdata, bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_sel;

    logic [31:0] bus_mem [0:127];
    logic [7:0]  ref_mem [0:511];
    int          n_checks = 0;
    int          n_fail = 0;

    dmem_ctrl #(.BUS_CYCLES(BC)) dut (
        .sck       (sck),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .size      (size),
        .sext      (sext),
        .addr      (addr),
        .wdata     (wdata),
        .ready     (ready),
        .done      (done),
        .rdata     (rdata),
        .addr_err  (addr_err),
        .bus_en    (bus_en),
        .bus_rw    (bus_rw),
        .bus_sel   (bus_sel),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata)
    );

    always #5 sck = ~sck;

    assign bus_rdata = bus_mem[bus_addr[8:2]];

    always @(posedge sck) begin
        if (bus_en && bus_rw) begin
            for (int i = 0; i < 4; i++)
                if (bus_sel[i]) bus_mem[bus_addr[8:2]][8*i +: 8] <= bus_wdata[8*i +: 8];
        end
    end

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'b11) || ((a % nbytes(sz)) != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sx, input logic [31:0] a);
        int          nb = nbytes(sz);
        int          off = int'(a - BASE);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[off + i]) << (8 * i));
        if (sx && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        return v;
    endfunction

    function automatic logic [3:0] ref_sel(input logic [1:0] sz, input logic [31:0] a);
        return 4'(((1 << nbytes(sz)) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int off = int'(a - BASE) & ~3;
        return {ref_mem[off+3], ref_mem[off+2], ref_mem[off+1], ref_mem[off]};
    endfunction

    function automatic bit rmw_on();
`ifdef DMEM_RMW_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int ref_lat(input logic w, input logic [1:0] sz, input logic [31:0] a);
        if (ref_err(sz, a)) return 1;
        if (w && nbytes(sz) < 4 && rmw_on()) return 2 * BC + 2;
        return BC + 1;
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int off = int'(a - BASE);
        for (int i = 0; i < nbytes(sz); i++) ref_mem[off + i] = wd[8*i +: 8];
    endtask

    task automatic set_word(input logic [31:0] a, input logic [31:0] w);
        int off = int'(a - BASE);
        bus_mem[off / 4] = w;
        for (int i = 0; i < 4; i++) ref_mem[(off & ~3) + i] = w[8*i +: 8];
    endtask

    // ---------------- access driver ----------------
    // Starts at a negedge with ready=1; returns at the negedge where ready is back (or budget spent).
    task automatic run_access(input logic w, input logic [1:0] sz, input logic sx,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int poke_n, input logic [31:0] poke_a,
                              output acc_res_t r);
        logic [3:0] exp_sel;
        bit         seen_wr;
        r = '{default: 0};
        seen_wr = 0;
        exp_sel = ref_sel(sz, a);
        we = w; size = sz; sext = sx; addr = a; wdata = wd; req = 1'b1;
        @(posedge sck);
        for (int n = 1; n <= 40; n++) begin
            @(negedge sck);
            if (n == 1) req = 1'b0;
            if (bus_en) begin
                if (bus_rw) r.wr_cyc++; else r.rd_cyc++;
                if (bus_addr !== {a[31:2], 2'b00}) r.bad_addr++;
                if (bus_sel !== (bus_rw ? exp_sel : 4'hF)) r.bad_sel++;
                if (bus_rw) begin
                    if (seen_wr && bus_wdata !== r.wr_data) r.bad_wd++;
                    r.wr_data = bus_wdata;
                    seen_wr = 1;
                end
            end
            if (done) begin
                r.n_done++;
                r.got = rdata;
                if (r.lat == 0) r.lat = n;
            end
            if (addr_err) begin
                r.n_err++;
                if (r.lat == 0) r.lat = n;
            end
            if (n == poke_n) begin
                req = 1'b1; addr = poke_a;
            end else if (n == poke_n + 1) begin
                req = 1'b0;
            end
            if (ready && r.lat != 0) begin
                r.ready_n = n;
                break;
            end
        end
        req = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int en_seen = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge sck);
            if (bus_en !== 1'b0) en_seen++;
        end
        n_checks++; if (en_seen !== 0) begin n_fail++; $display("FAIL reset_bus_quiet: bus_en high %0d cycles, want 0", en_seen); end
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
        n_checks++; if (done !== 1'b0 || addr_err !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: done=%b addr_err=%b want 0/0", done, addr_err); end
        n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        n_checks++; if (bus_rw !== 1'b0 || bus_sel !== 4'b0000) begin n_fail++; $display("FAIL reset_bus_ctl: rw=%b sel=%b want 0/0000", bus_rw, bus_sel); end
        n_checks++; if (bus_addr !== 32'd0 || bus_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_bus_data: addr=%h wdata=%h want 0/0", bus_addr, bus_wdata); end
        rst_n = 1'b1;
        @(negedge sck);
    endtask

    task automatic test_lw();
        acc_res_t r;
        set_word(BASE + 32'h4, 32'hDEAD_BEEF);
        run_access(1'b0, 2'b10, 1'b0, BASE + 32'h4, 32'd0, 0, 32'd0, r);
        n_checks++; if (r.lat !== BC + 1) begin n_fail++; $display("FAIL lw_latency: got %0d want %0d", r.lat, BC + 1); end
        n_checks++; if (r.rd_cyc !== BC || r.wr_cyc !== 0) begin n_fail++; $display("FAIL lw_bus_cycles: rd=%0d wr=%0d want %0d/0", r.rd_cyc, r.wr_cyc, BC); end
        n_checks++; if (r.bad_addr !== 0 || r.bad_sel !== 0) begin n_fail++; $display("FAIL lw_bus_fields: bad_addr=%0d bad_sel=%0d want 0/0", r.bad_addr, r.bad_sel); end
        n_checks++; if (r.got !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_rdata: got %h want deadbeef", r.got); end
        n_checks++; if (r.n_done !== 1 || r.ready_n !== r.lat + 1) begin n_fail++; $display("FAIL lw_handshake: done_cycles=%0d ready_at=%0d want 1/%0d", r.n_done, r.ready_n, r.lat + 1); end
        n_checks++; if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_rdata_hold: got %h want deadbeef", rdata); end
    endtask

    task automatic test_sub_loads();
        acc_res_t    r;
        logic [1:0]  szs  [3] = '{2'b00, 2'b00, 2'b01};
        logic        sxs  [3] = '{1'b1, 1'b0, 1'b0};
        logic [31:0] adrs [3] = '{BASE + 32'h7, BASE + 32'h7, BASE + 32'h2};
        logic [31:0] exps [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF};
        set_word(BASE + 32'h4, 32'h80FF_0000);
        set_word(BASE + 32'h0, 32'h80FF_0000);
        for (int i = 0; i < 3; i++) begin
            run_access(1'b0, szs[i], sxs[i], adrs[i], 32'd0, 0, 32'd0, r);
            n_checks++; if (r.got !== exps[i] || r.lat !== BC + 1) begin n_fail++; $display("FAIL sub_load_%0d: got %h lat %0d want %h lat %0d", i, r.got, r.lat, exps[i], BC + 1); end
        end
    endtask

    task automatic test_sb();
        acc_res_t    r;
        logic [31:0] exp_wd;
        set_word(BASE + 32'h0, 32'h1122_3344);
        exp_wd = rmw_on() ? 32'h1122_AA44 : 32'hAAAA_AAAA;
        run_access(1'b1, 2'b00, 1'b0, BASE + 32'h1, 32'hFFFF_FFAA, 0, 32'd0, r);
        ref_store(2'b00, BASE + 32'h1, 32'hFFFF_FFAA);
        n_checks++; if (r.lat !== ref_lat(1'b1, 2'b00, BASE + 32'h1)) begin n_fail++; $display("FAIL sb_latency: got %0d want %0d", r.lat, ref_lat(1'b1, 2'b00, BASE + 32'h1)); end
        n_checks++; if (r.wr_data !== exp_wd || r.bad_wd !== 0) begin n_fail++; $display("FAIL sb_wdata: got %h (unstable %0d) want %h", r.wr_data, r.bad_wd, exp_wd); end
        n_checks++; if (r.bad_sel !== 0 || r.wr_cyc !== BC) begin n_fail++; $display("FAIL sb_sel: bad_sel=%0d wr=%0d want 0/%0d", r.bad_sel, r.wr_cyc, BC); end
        n_checks++; if (r.rd_cyc !== (rmw_on() ? BC : 0)) begin n_fail++; $display("FAIL sb_read_phase: got %0d want %0d", r.rd_cyc, rmw_on() ? BC : 0); end
        n_checks++; if (bus_mem[0] !== 32'h1122_AA44) begin n_fail++; $display("FAIL sb_memory: got %h want 1122aa44", bus_mem[0]); end
    endtask

    task automatic test_errors();
        acc_res_t    r;
        logic [1:0]  szs  [3] = '{2'b10, 2'b01, 2'b11};
        logic [31:0] adrs [3] = '{BASE + 32'h2, BASE + 32'h1, BASE + 32'h0};
        for (int i = 0; i < 3; i++) begin
            run_access(1'b0, szs[i], 1'b0, adrs[i], 32'd0, 0, 32'd0, r);
            n_checks++; if (r.lat !== 1 || r.n_err !== 1 || r.n_done !== 0) begin n_fail++; $display("FAIL err_%0d: lat=%0d err=%0d done=%0d want 1/1/0", i, r.lat, r.n_err, r.n_done); end
            n_checks++; if (r.rd_cyc + r.wr_cyc !== 0 || r.ready_n !== 2) begin n_fail++; $display("FAIL err_%0d_bus: bus_cycles=%0d ready_at=%0d want 0/2", i, r.rd_cyc + r.wr_cyc, r.ready_n); end
        end
    endtask

    task automatic test_reset_mid();
        int wait_n = 0;
        int bad = 0;
        we = 1'b1; size = 2'b10; sext = 1'b0; addr = BASE + 32'h1F0; wdata = 32'h5555_AAAA; req = 1'b1;
        @(posedge sck);
        @(negedge sck);
        req = 1'b0;
        while (!(bus_en && bus_rw) && wait_n < 20) begin
            @(negedge sck);
            wait_n++;
        end
        n_checks++; if (!(bus_en && bus_rw)) begin n_fail++; $display("FAIL rst_mid_reach_wr: en=%b rw=%b want 1/1", bus_en, bus_rw); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (bus_en !== 1'b0) begin n_fail++; $display("FAIL rst_mid_bus_en: got %b want 0", bus_en); end
        @(negedge sck);
        rst_n = 1'b1;
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", ready); end
        for (int i = 0; i < 6; i++) begin
            @(negedge sck);
            if (done !== 1'b0 || bus_en !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rst_mid_abandon: %0d cycles with done/bus_en, want 0", bad); end
        set_word(BASE + 32'h1F0, 32'h0);
    endtask

    task automatic test_ignore_busy();
        acc_res_t r;
        int       extra = 0;
        set_word(BASE + 32'h8, 32'h0BAD_F00D);
        set_word(BASE + 32'h40, 32'h1234_5678);
        run_access(1'b0, 2'b10, 1'b0, BASE + 32'h8, 32'd0, 1, BASE + 32'h40, r);
        n_checks++; if (r.bad_addr !== 0 || r.rd_cyc !== BC) begin n_fail++; $display("FAIL busy_req_addr: bad_addr=%0d rd=%0d want 0/%0d", r.bad_addr, r.rd_cyc, BC); end
        n_checks++; if (r.got !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL busy_req_data: got %h want 0badf00d", r.got); end
        for (int i = 0; i < 4; i++) begin
            @(negedge sck);
            if (bus_en !== 1'b0 || ready !== 1'b1) extra++;
        end
        n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL busy_req_dropped: %0d busy cycles after done, want 0", extra); end
    endtask

    task automatic test_random();
        acc_res_t    r;
        logic        w, sx;
        logic [1:0]  sz;
        logic [31:0] a, wd, exp;
        int          elat;
        bit          err;
        for (int i = 0; i < 60; i++) begin
            w  = 1'($urandom_range(0, 1));
            sx = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a  = BASE + 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~(32'(nbytes(sz)) - 1);
            wd = $urandom;
            err  = ref_err(sz, a);
            elat = ref_lat(w, sz, a);
            exp  = err ? 32'd0 : ref_load(sz, sx, a);
            run_access(w, sz, sx, a, wd, 0, 32'd0, r);
            if (w && !err) ref_store(sz, a, wd);
            n_checks++; if (r.lat !== elat || r.n_err !== int'(err) || r.n_done !== int'(!err)) begin n_fail++; $display("FAIL rand_%0d_timing: lat=%0d err=%0d done=%0d want %0d/%0d/%0d", i, r.lat, r.n_err, r.n_done, elat, err, !err); end
            n_checks++; if (r.bad_addr !== 0 || r.bad_sel !== 0 || r.bad_wd !== 0) begin n_fail++; $display("FAIL rand_%0d_bus: bad_addr=%0d bad_sel=%0d bad_wd=%0d want 0", i, r.bad_addr, r.bad_sel, r.bad_wd); end
            if (!err && !w) begin
                n_checks++; if (r.got !== exp) begin n_fail++; $display("FAIL rand_%0d_load: addr %h size %0d got %h want %h", i, a, sz, r.got, exp); end
            end
            if (!err && w) begin
                n_checks++; if (bus_mem[int'(a - BASE) / 4] !== ref_word(a)) begin n_fail++; $display("FAIL rand_%0d_store: addr %h got %h want %h", i, a, bus_mem[int'(a - BASE) / 4], ref_word(a)); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) set_word(BASE + 32'(4 * i), $urandom);
        test_reset();
        test_lw();
        test_sub_loads();
        test_sb();
        test_errors();
        test_ignore_busy();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
